sram_stream_reader: RTL and testbench

//  Avalon-MM read master for the 5000x32 on-chip SRAM slave (fixed 1-cycle read latency).
//  On a start pulse, reads word_count words from base_addr upward. Emits them as an Avalon-ST packet (sop/eop) with full backpressure.

---
 rtl/sram_stream_pkg.sv | 30 +++
 rtl/sram_rd_fifo.sv | 60 ++++++
 rtl/sram_stream_reader.sv | 176 +++++++++++++++++
 tb/tb_sram_stream_reader.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_stream_pkg.sv
// Shared constants, FSM states and stream beat layout for the SRAM stream reader.
package sram_stream_pkg;

  localparam int unsigned NUMWORDS   = 5000;
  localparam int unsigned AW         = 13;
  localparam int unsigned DW         = 32;
  localparam int unsigned CW         = AW + 1;
  localparam int unsigned BEW        = 4;
  localparam int unsigned FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

  // One buffered stream beat: packet framing flags plus the SRAM word.
  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [DW-1:0] data;
  } beat_t;

  // Next sequential SRAM address, wrapping after the last word.
  function automatic logic [AW-1:0] addr_inc(input logic [AW-1:0] a);
    return (a == AW'(NUMWORDS - 1)) ? '0 : a + AW'(1);
  endfunction

endpackage

// File: rtl/sram_rd_fifo.sv
// Small synchronous FIFO buffering SRAM read returns in front of the stream port.
module sram_rd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 34
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               pop_data,
  output logic [$clog2(DEPTH):0]     used,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned UW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [UW-1:0] used_q;
  logic          do_push;
  logic          do_pop;

  assign do_pop   = pop && (used_q != '0);
  assign do_push  = push && ((used_q != UW'(DEPTH)) || do_pop);
  assign pop_data = mem_q[rd_ptr_q];
  assign used     = used_q;
  assign empty    = (used_q == '0);

  // Storage array; contents need no reset since pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointer and occupancy tracking; simultaneous push and pop leaves used unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   used_q <= used_q + UW'(1);
        2'b01:   used_q <= used_q - UW'(1);
        default: used_q <= used_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_stream_reader.sv
// Avalon-MM read master that streams a block of SRAM words out as one Avalon-ST packet.
module sram_stream_reader
  import sram_stream_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [AW-1:0]  base_addr,
  input  logic [AW-1:0]  word_count,
  output logic           busy,
  output logic           done,
  output logic [AW-1:0]  sram_address,
  output logic           sram_chipselect,
  output logic           sram_write,
  output logic [BEW-1:0] sram_byteenable,
  output logic           sram_clken,
  input  logic [DW-1:0]  sram_readdata,
  output logic [DW-1:0]  out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sop,
  output logic           out_eop
);

  localparam int unsigned UW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned OW = UW + 1;

  state_t        state_q;
  state_t        state_n;
  logic [CW-1:0] count_q;
  logic [CW-1:0] count_n;
  logic [CW-1:0] issued_q;
  logic [CW-1:0] issued_n;
  logic [CW-1:0] sent_q;
  logic [CW-1:0] sent_n;
  logic [CW-1:0] rcvd_q;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_n;
  logic          cs_q;
  logic          cs_n;
  logic          inflight_q;
  logic          busy_n;
  logic          done_n;

  logic [UW-1:0] fifo_used;
  logic          fifo_empty;
  logic          push;
  logic          pop;
  logic [OW-1:0] outstanding;
  beat_t         push_beat;
  beat_t         head_beat;

  assign sram_write      = 1'b0;
  assign sram_byteenable = {BEW{1'b1}};
  assign sram_clken      = 1'b1;
  assign sram_address    = addr_q;
  assign sram_chipselect = cs_q;

  // Read data returns one cycle after the issued read and is pushed that cycle.
  assign push = inflight_q;
  assign pop  = !fifo_empty && out_ready;

  // Words buffered plus reads on the bus or returning; never allowed past FIFO_DEPTH.
  assign outstanding = OW'(fifo_used) + OW'(cs_q) + OW'(inflight_q);

  // Framing is decided at capture time from the receive index.
  assign push_beat.sop  = (rcvd_q == '0);
  assign push_beat.eop  = (rcvd_q == count_q - CW'(1));
  assign push_beat.data = sram_readdata;

  assign out_valid = !fifo_empty;
  assign out_data  = head_beat.data;
  assign out_sop   = head_beat.sop;
  assign out_eop   = head_beat.eop;

  sram_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     ($bits(beat_t))
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_beat),
    .pop       (pop),
    .pop_data  (head_beat),
    .used      (fifo_used),
    .empty     (fifo_empty)
  );

  // Next-state, read issue and credit decisions.
  always_comb begin
    state_n  = state_q;
    count_n  = count_q;
    issued_n = issued_q;
    sent_n   = sent_q;
    addr_n   = addr_q;
    cs_n     = 1'b0;

    if (pop) begin
      sent_n = sent_q + CW'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          count_n  = CW'(word_count);
          issued_n = '0;
          sent_n   = '0;
          if (word_count == '0) begin
            state_n = DONE;
          end else begin
            state_n  = READ;
            cs_n     = 1'b1;
            issued_n = CW'(1);
            addr_n   = (base_addr < AW'(NUMWORDS)) ? base_addr : '0;
          end
        end
      end
      READ: begin
        if (issued_q == count_q) begin
          state_n = DRAIN;
        end else if (outstanding < OW'(FIFO_DEPTH)) begin
          cs_n     = 1'b1;
          issued_n = issued_q + CW'(1);
          addr_n   = addr_inc(addr_q);
        end
      end
      DRAIN: begin
        if (pop && (sent_q == count_q - CW'(1))) begin
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n == READ) || (state_n == DRAIN);
    done_n = (state_n == DONE);
  end

  // State, counters, bus-side registers and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      count_q    <= '0;
      issued_q   <= '0;
      sent_q     <= '0;
      rcvd_q     <= '0;
      addr_q     <= '0;
      cs_q       <= 1'b0;
      inflight_q <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_n;
      count_q    <= count_n;
      issued_q   <= issued_n;
      sent_q     <= sent_n;
      addr_q     <= addr_n;
      cs_q       <= cs_n;
      inflight_q <= cs_q;
      busy       <= busy_n;
      done       <= done_n;
      if ((state_q == IDLE) && start) begin
        rcvd_q <= '0;
      end else if (push) begin
        rcvd_q <= rcvd_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader with a 1-cycle-latency SRAM model.
module tb_sram_stream_reader;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [31:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [12:0] base_addr;
  logic [12:0] word_count;
  logic        busy;
  logic        done;
  logic [12:0] sram_address;
  logic        sram_chipselect;
  logic        sram_write;
  logic [3:0]  sram_byteenable;
  logic        sram_clken;
  logic [31:0] sram_readdata;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_sop;
  logic        out_eop;

  logic [31:0] mem [5000];
  exp_t        exp_q[$];
  int          addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int eop_cyc  = 0;
  int done_cyc = 0;
  int issued   = 0;
  int accepted = 0;
  bit prev_stall = 0;
  logic [33:0] prev_beat = '0;

  sram_stream_reader dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .base_addr       (base_addr),
    .word_count      (word_count),
    .busy            (busy),
    .done            (done),
    .sram_address    (sram_address),
    .sram_chipselect (sram_chipselect),
    .sram_write      (sram_write),
    .sram_byteenable (sram_byteenable),
    .sram_clken      (sram_clken),
    .sram_readdata   (sram_readdata),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_sop         (out_sop),
    .out_eop         (out_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM slave: registered read, data valid the cycle after chipselect.
  always @(posedge clk) begin
    if (sram_chipselect) sram_readdata <= mem[sram_address];
  end

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Monitor: stream and address scoreboards, stall stability and credit bound.
  always @(negedge clk) begin
    if (reset) begin
      prev_stall = 0;
      issued     = 0;
      accepted   = 0;
      exp_q.delete();
      addr_q.delete();
    end else begin
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_beat_hold", {out_sop, out_eop, out_data}, prev_beat);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat", out_data);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("beat", {out_sop, out_eop, out_data}, {e.sop, e.eop, e.data});
          accepted++;
        end
        if (out_eop) eop_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = {out_sop, out_eop, out_data};
      if (sram_chipselect) begin
        issued++;
        if (addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_read: got address %0d, expected no read", sram_address);
        end else begin
          int a;
          a = addr_q.pop_front();
          check("read_address", sram_address, a);
        end
        check("credit_bound", (issued - accepted) <= 4, 1);
      end
    end
  end

  // Model of one packet: clamped base, wrapping address, sop/eop framing.
  task automatic push_model(input int b, input int n);
    int a;
    exp_t e;
    a = (b < 5000) ? b : 0;
    for (int i = 0; i < n; i++) begin
      e.data = 32'(a);
      e.sop  = (i == 0);
      e.eop  = (i == n - 1);
      exp_q.push_back(e);
      addr_q.push_back(a);
      a = (a == 4999) ? 0 : a + 1;
    end
  endtask

  task automatic push_lit(input int a, input logic [31:0] d, input bit s, input bit e);
    exp_t x;
    x.data = d;
    x.sop  = s;
    x.eop  = e;
    exp_q.push_back(x);
    addr_q.push_back(a);
  endtask

  // Returns just after the edge that samples start.
  task automatic issue_start(input logic [12:0] b, input logic [12:0] n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = b; word_count = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles, output bit valid_seen);
    cycles = 0;
    valid_seen = 0;
    do begin
      @(negedge clk);
      cycles++;
      if (out_valid) valid_seen = 1;
    end while (!done && cycles < budget);
    check("done_seen", done, 1);
    done_cyc = cyc;
    @(negedge clk);
    check("done_pulse_width", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cycles;
    bit  vseen;
    bit  got;
    bit  bad;
    int  c;

    for (int i = 0; i < 5000; i++) mem[i] = 32'(i);
    reset = 1'b1; start = 1'b0; base_addr = '0; word_count = '0; out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_valid", out_valid, 0);
    check("rst_cs", sram_chipselect, 0);
    check("rst_addr", sram_address, 0);
    check("const_bus", {sram_write, sram_byteenable, sram_clken}, 6'b0_1111_1);
    @(posedge clk); #1;
    reset = 1'b0;

    // Basic: base 10, count 4
    push_lit(10, 32'd10, 1, 0);
    push_lit(11, 32'd11, 0, 0);
    push_lit(12, 32'd12, 0, 0);
    push_lit(13, 32'd13, 0, 1);
    issue_start(13'd10, 13'd4);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (!out_valid && cycles < 20);
    check("first_valid_latency", cycles, 3);
    check("busy_in_transfer", busy, 1);
    wait_done(50, cycles, vseen);
    check("done_after_eop", done_cyc - eop_cyc, 1);
    check("basic_drained", exp_q.size(), 0);

    // Backpressure: count 16, toggling ready then a 20-cycle stall
    push_model(100, 16);
    issue_start(13'd100, 13'd16);
    got = 0;
    c = 0;
    while (!got && c < 400) begin
      @(posedge clk); #1;
      out_ready = (c >= 6 && c < 26) ? 1'b0 : ((c % 2) == 0);
      @(negedge clk);
      if (c == 25) begin
        check("stall_cs_idle", sram_chipselect, 0);
        check("stall_valid", out_valid, 1);
      end
      if (done) got = 1;
      c++;
    end
    check("bp_done", got, 1);
    out_ready = 1'b1;
    check("bp_drained", exp_q.size(), 0);
    check("bp_reads", addr_q.size(), 0);

    // Address wrap
    push_model(4998, 4);
    issue_start(13'd4998, 13'd4);
    wait_done(50, cycles, vseen);
    check("wrap_drained", exp_q.size(), 0);

    // Empty transfer
    issue_start(13'd5, 13'd0);
    wait_done(20, cycles, vseen);
    check("zero_done_latency", cycles, 1);
    check("zero_no_valid", vseen, 0);

    // Single beat
    push_lit(7, 32'd7, 1, 1);
    issue_start(13'd7, 13'd1);
    wait_done(50, cycles, vseen);
    check("single_done_after_eop", done_cyc - eop_cyc, 1);
    check("single_drained", exp_q.size(), 0);

    // Out-of-range base clamps to 0
    push_model(6000, 2);
    issue_start(13'd6000, 13'd2);
    wait_done(50, cycles, vseen);
    check("clamp_drained", exp_q.size(), 0);

    // Reset three cycles into a long transfer
    push_model(200, 100);
    issue_start(13'd200, 13'd100);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_cs", sram_chipselect, 0);
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done || out_valid) bad = 1;
    end
    check("abort_quiet", bad, 0);
    push_model(300, 5);
    issue_start(13'd300, 13'd5);
    wait_done(50, cycles, vseen);
    check("after_abort_drained", exp_q.size(), 0);

    // Second start while busy is ignored
    push_model(50, 6);
    issue_start(13'd50, 13'd6);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 13'd900; word_count = 13'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(60, cycles, vseen);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || out_valid || busy) bad = 1;
    end
    check("busy_start_ignored", bad, 0);
    check("busy_drained", exp_q.size(), 0);
    check("busy_reads", addr_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
